// File: rtl/la_pkg.sv
// rtl/la_pkg.sv - shared state encoding and frame marker bytes for the readout sequencer
//
// Purpose: state encoding and default frame bytes shared by the sequencer RTL
//          and the host-side frame decoder model.
// Ports:   none (package).
package la_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_REQ,
    ST_WAIT,
    ST_LATCH,
    ST_SEND,
    ST_TRL,
    ST_CNT
  } seq_state_e;

  localparam logic [7:0] LA_HDR_BYTE = 8'hA5;
  localparam logic [7:0] LA_TRL_BYTE = 8'h5A;

endpackage

// File: rtl/readout_sequencer.sv
// rtl/readout_sequencer.sv - dumps a capture FIFO as a framed byte stream
//
// Purpose: on i_start, emits HDR_BYTE, then every FIFO word LSB byte first,
//          then TRL_BYTE and the saturating word count (LSB byte first).
// Ports:
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_start, i_abort              start a dump / cancel a dump in progress
//   i_fifo_empty, i_fifo_q        capture FIFO status and read data (non-showahead)
//   o_fifo_rdreq                  FIFO read strobe
//   o_byte, o_byte_valid,
//   i_byte_ready                  outgoing byte stream with valid/ready handshake
//   o_busy, o_done                dump in progress / 1-cycle frame-complete pulse
module readout_sequencer
  import la_pkg::*;
#(
  parameter logic [7:0] HDR_BYTE = LA_HDR_BYTE,
  parameter logic [7:0] TRL_BYTE = LA_TRL_BYTE,
  parameter int         CNT_W    = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic        i_fifo_empty,
  input  logic [31:0] i_fifo_q,
  output logic        o_fifo_rdreq,
  output logic [7:0]  o_byte,
  output logic        o_byte_valid,
  input  logic        i_byte_ready,
  output logic        o_busy,
  output logic        o_done
);

  // Index of the last count byte: one byte for an 8-bit counter, two for 16.
  localparam logic [1:0] CNT_LAST = (CNT_W == 16) ? 2'd1 : 2'd0;

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      shift_q, shift_d;
  logic [1:0]       idx_q, idx_d;
  logic             done_q, done_d;
  logic             xfer;
  logic [7:0]       cnt_byte;

  assign xfer   = o_byte_valid & i_byte_ready;
  assign o_done = done_q;

  if (CNT_W == 16) begin : g_cnt16
    assign cnt_byte = idx_q[0] ? cnt_q[15:8] : cnt_q[7:0];
  end else begin : g_cnt8
    assign cnt_byte = cnt_q[7:0];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    idx_d        = idx_q;
    done_d       = 1'b0;
    o_fifo_rdreq = 1'b0;
    o_byte_valid = 1'b0;
    o_byte       = 8'h00;
    o_busy       = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_HDR;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      ST_HDR: begin
        o_byte_valid = 1'b1;
        o_byte       = HDR_BYTE;
        if (xfer) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (i_fifo_empty) begin
          state_d = ST_TRL;
        end else begin
          // An abort in this cycle must not pop a word it would then drop.
          o_fifo_rdreq = ~i_abort;
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // FIFO output register updates on the edge ending the rdreq cycle.
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        shift_d = i_fifo_q;
        cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        idx_d   = '0;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        o_byte_valid = 1'b1;
        o_byte       = shift_q[7:0];
        if (xfer) begin
          shift_d = {8'h00, shift_q[31:8]};
          if (idx_q == 2'd3) begin
            idx_d   = '0;
            state_d = ST_REQ;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      ST_TRL: begin
        o_byte_valid = 1'b1;
        o_byte       = TRL_BYTE;
        if (xfer) begin
          idx_d   = '0;
          state_d = ST_CNT;
        end
      end
      ST_CNT: begin
        o_byte_valid = 1'b1;
        o_byte       = cnt_byte;
        if (xfer) begin
          if (idx_q == CNT_LAST) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over any transfer completing in the same cycle; a latched
    // word is dropped and the counter keeps only words already captured.
    if (i_abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      cnt_d   = cnt_q;
      shift_d = '0;
      idx_d   = '0;
      done_d  = 1'b0;
    end
  end

endmodule

// File: tb/tb_readout_sequencer.sv
// tb/tb_readout_sequencer.sv - self-checking bench for readout_sequencer
module tb_readout_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        byte_ready = 1'b1;
  logic [31:0] fifo_q = 32'h0;
  logic        fifo_empty;

  logic        rdreq16, valid16, busy16, done16;
  logic [7:0]  byte16;
  logic        rdreq8, valid8, busy8, done8;
  logic [7:0]  byte8;

  logic [31:0] mem [0:511];
  int          rd_ptr = 0;
  int          wr_len = 0;
  assign fifo_empty = (rd_ptr >= wr_len);

  always #5 clk = ~clk;

  readout_sequencer #(.CNT_W(16)) dut16 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_fifo_empty(fifo_empty), .i_fifo_q(fifo_q), .o_fifo_rdreq(rdreq16),
    .o_byte(byte16), .o_byte_valid(valid16), .i_byte_ready(byte_ready),
    .o_busy(busy16), .o_done(done16)
  );

  readout_sequencer #(.CNT_W(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_fifo_empty(fifo_empty), .i_fifo_q(fifo_q), .o_fifo_rdreq(rdreq8),
    .o_byte(byte8), .o_byte_valid(valid8), .i_byte_ready(byte_ready),
    .o_busy(busy8), .o_done(done8)
  );

  typedef struct {
    int               n_words;
    logic [3:0][31:0] words;
    bit               toggle;
    int               exp_len;
    logic [15:0][7:0] exp;
    int               exp_rdreq;
  } vec_t;

  vec_t       vecs [4];
  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] got16 [$];
  logic [7:0] got8 [$];
  int         cyc, n_rdreq, n_done16, n_done8, bad_rd, bad_stall;
  int         first_rd_cyc, first_dat_cyc;
  bit         toggle, stall16, stall8;
  logic [7:0] stall_byte16, stall_byte8;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic clear_obs();
    got16.delete();
    got8.delete();
    n_rdreq = 0; n_done16 = 0; n_done8 = 0; bad_rd = 0; bad_stall = 0;
    first_rd_cyc = -1; first_dat_cyc = -1; cyc = 0;
    stall16 = 1'b0; stall8 = 1'b0;
  endtask

  // One clock: sample at the falling edge, then emulate the FIFO read port
  // and the ready pattern just after the rising edge.
  task automatic tick();
    bit rd_now;
    @(negedge clk);
    cyc++;
    if (rdreq16) begin
      n_rdreq++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
    end
    if ((rdreq16 || rdreq8) && fifo_empty) bad_rd++;
    if (valid16 && got16.size() == 1 && first_dat_cyc < 0) first_dat_cyc = cyc;
    if (stall16 && (!valid16 || byte16 !== stall_byte16)) bad_stall++;
    if (stall8 && (!valid8 || byte8 !== stall_byte8)) bad_stall++;
    stall16 = valid16 && !byte_ready && !abort && !rst;
    stall8  = valid8 && !byte_ready && !abort && !rst;
    stall_byte16 = byte16;
    stall_byte8  = byte8;
    if (valid16 && byte_ready) got16.push_back(byte16);
    if (valid8 && byte_ready) got8.push_back(byte8);
    if (done16) n_done16++;
    if (done8) n_done8++;
    rd_now = rdreq16;
    @(posedge clk);
    #1;
    if (rd_now) begin
      fifo_q = mem[rd_ptr];
      rd_ptr++;
    end
    if (toggle) byte_ready = ~byte_ready;
  endtask

  task automatic run_frame(input string name, input int max_cyc);
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while ((busy16 || busy8) && n < max_cyc) begin
      tick();
      n++;
    end
    check({name, "_timeout"}, (n >= max_cyc), 1'b0);
    tick();
    tick();
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_rdreq"}, {rdreq16, rdreq8}, 2'b00);
    check({name, "_valid"}, {valid16, valid8}, 2'b00);
    check({name, "_busy"},  {busy16, busy8}, 2'b00);
    check({name, "_done"},  {done16, done8}, 2'b00);
    check({name, "_byte"},  {byte16, byte8}, 16'h0000);
  endtask

  initial begin
    vecs[0].n_words = 0; vecs[0].toggle = 0; vecs[0].exp_len = 4; vecs[0].exp_rdreq = 0;
    vecs[0].words = '0;
    vecs[0].exp = '0;
    vecs[0].exp[0] = 8'hA5; vecs[0].exp[1] = 8'h5A; vecs[0].exp[2] = 8'h00; vecs[0].exp[3] = 8'h00;

    vecs[1].n_words = 2; vecs[1].toggle = 0; vecs[1].exp_len = 12; vecs[1].exp_rdreq = 2;
    vecs[1].words = '0;
    vecs[1].words[0] = 32'h000112AB; vecs[1].words[1] = 32'h00020034;
    vecs[1].exp = {32'h0, 8'h00, 8'h02, 8'h5A, 8'h00, 8'h02, 8'h00, 8'h34,
                   8'h00, 8'h01, 8'h12, 8'hAB, 8'hA5};

    vecs[2].n_words = 1; vecs[2].toggle = 1; vecs[2].exp_len = 8; vecs[2].exp_rdreq = 1;
    vecs[2].words = '0;
    vecs[2].words[0] = 32'hDEADBEEF;
    vecs[2].exp = {64'h0, 8'h00, 8'h01, 8'h5A, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hA5};

    vecs[3].n_words = 3; vecs[3].toggle = 0; vecs[3].exp_len = 16; vecs[3].exp_rdreq = 3;
    vecs[3].words = '0;
    vecs[3].words[0] = 32'h01020304; vecs[3].words[1] = 32'hFFFFFFFF; vecs[3].words[2] = 32'h00000000;
    vecs[3].exp = {8'h00, 8'h03, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF,
                   8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'hA5};

    toggle = 0;
    clear_obs();

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table-driven frames.
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < vecs[v].n_words; i++) mem[i] = vecs[v].words[i];
      wr_len = vecs[v].n_words;
      rd_ptr = 0;
      clear_obs();
      toggle = vecs[v].toggle;
      byte_ready = 1'b1;
      run_frame($sformatf("v%0d", v), 300);
      toggle = 0;
      byte_ready = 1'b1;
      check($sformatf("v%0d_len16", v), got16.size(), vecs[v].exp_len);
      for (int i = 0; i < vecs[v].exp_len; i++)
        if (i < got16.size()) check($sformatf("v%0d_b16_%0d", v, i), got16[i], vecs[v].exp[i]);
      check($sformatf("v%0d_len8", v), got8.size(), vecs[v].exp_len - 1);
      for (int i = 0; i < vecs[v].exp_len - 1; i++)
        if (i < got8.size()) check($sformatf("v%0d_b8_%0d", v, i), got8[i], vecs[v].exp[i]);
      check($sformatf("v%0d_rdreq", v), n_rdreq, vecs[v].exp_rdreq);
      check($sformatf("v%0d_done", v), {n_done16[7:0], n_done8[7:0]}, 16'h0101);
      check($sformatf("v%0d_rd_empty", v), bad_rd, 0);
      check($sformatf("v%0d_stall", v), bad_stall, 0);
      if (vecs[v].n_words > 0 && !vecs[v].toggle)
        check($sformatf("v%0d_latency", v), first_dat_cyc - first_rd_cyc, 3);
    end

    // Abort while the second byte of a word is on the bus.
    mem[0] = 32'hDEADBEEF;
    wr_len = 1; rd_ptr = 0;
    clear_obs();
    byte_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int n = 0; n < 50 && got16.size() < 2; n++) tick();
    check("abort_reach", got16.size(), 2);
    check("abort_byte", byte16, 8'hBE);
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_valid", {valid16, valid8}, 2'b00);
    check("abort_busy", {busy16, busy8}, 2'b00);
    repeat (3) tick();
    check("abort_nodone", n_done16 + n_done8, 0);
    clear_obs();
    run_frame("after_abort", 300);
    check("after_abort_len", got16.size(), 4);
    if (got16.size() == 4)
      check("after_abort_bytes", {got16[0], got16[1], got16[2], got16[3]}, 32'hA55A0000);
    check("after_abort_done", n_done16, 1);

    // Reset mid-SEND, with a second start ignored while busy.
    mem[0] = 32'h11223344; mem[1] = 32'hCAFE0102;
    wr_len = 2; rd_ptr = 0;
    clear_obs();
    start = 1'b1; tick(); start = 1'b0;
    for (int n = 0; n < 50 && got16.size() < 1; n++) tick();
    start = 1'b1; tick(); start = 1'b0;
    for (int n = 0; n < 50 && got16.size() < 2; n++) tick();
    check("rst_pre_len", got16.size(), 2);
    if (got16.size() == 2) check("rst_pre_bytes", {got16[0], got16[1]}, 16'hA544);
    #2;
    rst = 1'b1;
    #1;
    check_idle_outputs("rst_async");
    tick(); tick();
    check("rst_hold_rdreq", n_rdreq, 1);
    check("rst_hold_done", n_done16 + n_done8, 0);
    rst = 1'b0;
    clear_obs();
    run_frame("after_rst", 300);
    check("after_rst_len", got16.size(), 8);
    if (got16.size() == 8)
      check("after_rst_bytes", {got16[0], got16[1], got16[2], got16[3], got16[4], got16[5], got16[6], got16[7]},
            64'hA5_02_01_FE_CA_5A_01_00);

    // 300 words: 8-bit count saturates, 16-bit count reads 0x012C.
    for (int i = 0; i < 300; i++) mem[i] = i;
    wr_len = 300; rd_ptr = 0;
    clear_obs();
    run_frame("sat", 3000);
    check("sat_len8", got8.size(), 1203);
    if (got8.size() == 1203) check("sat_cnt8", got8[1202], 8'hFF);
    check("sat_len16", got16.size(), 1204);
    if (got16.size() == 1204) check("sat_cnt16", {got16[1203], got16[1202]}, 16'h012C);
    check("sat_rdreq", n_rdreq, 300);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
